char_stream_consumer: RTL and testbench
=======================================

// Module: char_stream_consumer
// PURPOSE
//  Requesting end of the character-source handshake. Pulses new_char_request, captures the
//  24-bit word the source returns, and writes its low byte into on-chip RAM at consecutive
//  addresses. Checks each character for plaintext validity (lowercase a-z or space).
//  Sits between the character/key source and the message RAM and checker in the lab top level.
// PARAMETERS
//  NUM_CHARS    32  characters fetched per run (1..2**ADDR_W)
//  ADDR_W       5   RAM address width
//  DATA_W       24  width of source word char_in
//  STOP_ON_BAD  0   1: abort the run after the first invalid character; 0: fetch all NUM_CHARS
// PORTS
//  clock             in   1       rising-edge clock, only clock
//  reset             in   1       synchronous, active-high
//  start             in   1       begin a run; sampled only in IDLE
//  char_in           in   DATA_W  source word; valid the cycle after a request cycle
//  new_char_request  out  1       one-cycle request pulse to the source
//  wr_addr           out  ADDR_W  RAM write address
//  wr_data           out  8       RAM write data = char_in[7:0]
//  wr_en             out  1       RAM write strobe, one cycle per character
//  busy              out  1       high from the cycle after start until done
//  done              out  1       one-cycle pulse at end of run
//  all_valid         out  1       1 if every written character was valid; held until next start
//  bad_index         out  ADDR_W  index of first invalid character; held until next start
//  char_count        out  ADDR_W+1 characters written this run
// BEHAVIOUR
//  Clock and reset: single clock, clock; reset is synchronous, active-high.
//  Reset: state=IDLE. new_char_request, wr_en, busy, done, wr_addr, wr_data, bad_index and
//   char_count are 0. all_valid is 1. Reset mid-run aborts immediately, with no further
//   request or write.
//  FSM: IDLE -> REQ -> CAPTURE -> WRITE -> (REQ | FINISH) -> IDLE.
//   IDLE: start=1 moves to REQ and clears char_count/bad_index, sets all_valid=1; start ignored elsewhere.
//   REQ: new_char_request=1 for exactly one cycle. The source updates char_in at this edge.
//   CAPTURE: register char_in into cap_q. Evaluate valid = (cap[23:8]==0) &&
//    (cap[7:0] in 97..122 || cap[7:0]==32).
//   WRITE: wr_en=1, wr_addr=idx, wr_data=cap_q[7:0]. Invalid characters are still written.
//    On the first invalid character, all_valid<=0 and bad_index<=idx; later invalid ones
//    leave bad_index unchanged.
//    char_count<=idx+1. Next state is FINISH if idx==NUM_CHARS-1 or (STOP_ON_BAD && !valid);
//    otherwise idx+1 and REQ.
//   FINISH: done=1 for one cycle, busy=0 next cycle, back to IDLE.
//  Latency: 3 cycles per character (REQ, CAPTURE, WRITE). A full run takes 3*NUM_CHARS+1
//   cycles from the start-sampled edge to the done pulse.
//  Exactly one request per written character. Never two requests without an intervening WRITE.
//  idx is ADDR_W+1 bits wide, so NUM_CHARS = 2**ADDR_W causes no wrap. wr_addr uses idx[ADDR_W-1:0].
//  start held high through FINISH does not retrigger until IDLE samples it again (one-cycle gap).
// STRUCTURE
//  char_pkg: state enum {IDLE,REQ,CAPTURE,WRITE,FINISH}, ASCII_LO_A=97, ASCII_LO_Z=122,
//   ASCII_SPACE=32.
//  Sub-module char_validator: combinational, word in -> valid out. Reused by the key-search checker.
// TESTING (source model: reset a=94, b=97, alternates returning b then a, post-increment)
//  Reset then start, NUM_CHARS=4, STOP_ON_BAD=0 -> writes 97,95,98,96 at addr 0..3.
//   Expect all_valid=0, bad_index=1, char_count=4, and one done pulse at cycle 13.
//  Same stimulus with STOP_ON_BAD=1 -> writes only addr0=97 and addr1=95.
//   Expect char_count=2, bad_index=1, done 7 cycles after start, and exactly 2 request pulses.
//  Source forced to 'a'..'z' then 32, NUM_CHARS=32 -> 32 writes, all_valid=1, char_count=32,
//   wr_addr reaches 31 without wrap.
//  char_in=24'h010061 (upper bits set) -> character flagged invalid and bad_index=0.
//  Reset asserted in the CAPTURE of char 2 -> the next cycle has all outputs at reset values,
//   no wr_en follows, and a new start restarts at addr 0.
//  start pulsed while busy -> ignored; request count equals NUM_CHARS.

Source files
------------

// File: rtl/char_pkg.sv
// Shared definitions for the character-stream consumer and its validator.
//   State encodings for the consumer FSM, ASCII bounds for plaintext, and a
//   helper that classifies one byte as plaintext (lowercase a-z or space).
package char_pkg;

  // Consumer FSM states
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] REQ     = 3'd1;
  localparam logic [2:0] CAPTURE = 3'd2;
  localparam logic [2:0] WRITE   = 3'd3;
  localparam logic [2:0] FINISH  = 3'd4;

  localparam logic [7:0] ASCII_LO_A  = 8'd97;
  localparam logic [7:0] ASCII_LO_Z  = 8'd122;
  localparam logic [7:0] ASCII_SPACE = 8'd32;

  // True for a lowercase letter or a space
  function automatic logic is_plain_char(input logic [7:0] c);
    return ((c >= ASCII_LO_A) && (c <= ASCII_LO_Z)) || (c == ASCII_SPACE);
  endfunction

endpackage

// File: rtl/char_validator.sv
// Combinational plaintext check on one source word.
//   word     in   DATA_W  source word; only the low byte may be non-zero
//   valid_c  out  1       1 when upper bits are clear and the low byte is a-z or space
module char_validator
  import char_pkg::*;
#(
  parameter int unsigned DATA_W = 24
) (
  input  logic [DATA_W-1:0] word,
  output logic              valid_c
);

  assign valid_c = (word[DATA_W-1:8] == '0) && is_plain_char(word[7:0]);

endmodule

// File: rtl/char_stream_consumer.sv
// Requesting end of the character-source handshake. Each run fetches up to
// NUM_CHARS words, writes their low bytes to consecutive RAM addresses and
// tracks whether every character was plaintext.
//   clock             in   1         rising-edge clock
//   reset             in   1         synchronous, active-high
//   start             in   1         begin a run (sampled in IDLE only)
//   char_in           in   DATA_W    source word, valid the cycle after a request
//   new_char_request  out  1         one-cycle request pulse to the source
//   wr_addr           out  ADDR_W    RAM write address
//   wr_data           out  8         RAM write data
//   wr_en             out  1         RAM write strobe
//   busy              out  1         run in progress
//   done              out  1         one-cycle end-of-run pulse
//   all_valid         out  1         every written character was valid
//   bad_index         out  ADDR_W    index of first invalid character
//   char_count        out  ADDR_W+1  characters written this run
module char_stream_consumer
  import char_pkg::*;
#(
  parameter int unsigned NUM_CHARS   = 32,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned DATA_W      = 24,
  parameter bit          STOP_ON_BAD = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] char_in,
  output logic              new_char_request,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              wr_en,
  output logic              busy,
  output logic              done,
  output logic              all_valid,
  output logic [ADDR_W-1:0] bad_index,
  output logic [ADDR_W:0]   char_count
);

  // idx is one bit wider than the address so NUM_CHARS = 2**ADDR_W cannot wrap
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(NUM_CHARS - 1);
  localparam logic [ADDR_W:0] IDX_ONE  = (ADDR_W+1)'(1);

  logic [2:0]        state_q;
  logic [2:0]        state_d;
  logic [ADDR_W:0]   idx_q;
  logic [DATA_W-1:0] cap_q;
  logic              cap_valid_c;
  logic              last_c;

  char_validator #(.DATA_W(DATA_W)) u_validator (
    .word    (cap_q),
    .valid_c (cap_valid_c)
  );

  assign last_c = (idx_q == LAST_IDX);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = REQ;
      REQ:     state_d = CAPTURE;
      CAPTURE: state_d = WRITE;
      WRITE:   state_d = (last_c || (STOP_ON_BAD && !cap_valid_c)) ? FINISH : REQ;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, registered strobes and datapath
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= IDLE;
      idx_q            <= '0;
      cap_q            <= '0;
      new_char_request <= 1'b0;
      wr_en            <= 1'b0;
      wr_addr          <= '0;
      wr_data          <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      all_valid        <= 1'b1;
      bad_index        <= '0;
      char_count       <= '0;
    end else begin
      state_q          <= state_d;
      // Strobes are decoded from the next state so they line up with it
      new_char_request <= (state_d == REQ);
      wr_en            <= (state_d == WRITE);
      busy             <= (state_d != IDLE);
      done             <= (state_d == FINISH);
      case (state_q)
        IDLE: begin
          if (start) begin
            idx_q      <= '0;
            char_count <= '0;
            bad_index  <= '0;
            all_valid  <= 1'b1;
          end
        end
        CAPTURE: begin
          // wr_data/wr_addr load alongside cap_q so the write lands in WRITE
          cap_q   <= char_in;
          wr_addr <= idx_q[ADDR_W-1:0];
          wr_data <= char_in[7:0];
        end
        WRITE: begin
          char_count <= idx_q + IDX_ONE;
          idx_q      <= idx_q + IDX_ONE;
          // all_valid still high means this is the first invalid character
          if (!cap_valid_c && all_valid) begin
            all_valid <= 1'b0;
            bad_index <= idx_q[ADDR_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_char_stream_consumer.sv
// Scoreboard bench: three consumers (4 chars, 4 chars stop-on-bad, 32 chars)
// each fed by a behavioural character source; expected writes are queued at
// stimulus time and popped by a monitor whenever any consumer strobes wr_en.
module tb_char_stream_consumer;

  typedef struct {
    int inst;
    int addr;
    int data;
  } wr_t;

  logic       clock;
  logic       reset;
  logic [2:0] start;
  logic [2:0] ncr;
  logic [2:0] wr_en;
  logic [2:0] busy;
  logic [2:0] done;
  logic [2:0] all_valid;
  logic [4:0] wr_addr    [3];
  logic [7:0] wr_data    [3];
  logic [4:0] bad_index  [3];
  logic [5:0] char_count [3];
  logic       override;

  wr_t exp_q[$];
  int  req_cnt [3];
  int  total;
  int  bad;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned NC    = (g == 2) ? 32 : 4;
    localparam bit          SB    = (g == 1);
    localparam bit          ALPHA = (g == 2);

    logic [23:0] src_q;
    int          a;
    int          b;
    int          k;
    logic        tog;

    char_stream_consumer #(
      .NUM_CHARS   (NC),
      .ADDR_W      (5),
      .DATA_W      (24),
      .STOP_ON_BAD (SB)
    ) u_dut (
      .clock            (clock),
      .reset            (reset),
      .start            (start[g]),
      .char_in          (src_q),
      .new_char_request (ncr[g]),
      .wr_addr          (wr_addr[g]),
      .wr_data          (wr_data[g]),
      .wr_en            (wr_en[g]),
      .busy             (busy[g]),
      .done             (done[g]),
      .all_valid        (all_valid[g]),
      .bad_index        (bad_index[g]),
      .char_count       (char_count[g])
    );

    // Source: answers each request at the request edge
    always @(posedge clock) begin
      if (reset) begin
        a     <= 94;
        b     <= 97;
        k     <= 0;
        tog   <= 1'b0;
        src_q <= '0;
      end else if (ncr[g]) begin
        if (override) begin
          src_q <= 24'h010061;
        end else if (ALPHA) begin
          src_q <= (k < 26) ? 24'(97 + k) : 24'd32;
          k     <= k + 1;
        end else if (!tog) begin
          src_q <= 24'(b);
          b     <= b + 1;
          tog   <= 1'b1;
        end else begin
          src_q <= 24'(a + 1);
          a     <= a + 1;
          tog   <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor: counts requests and checks every write against the queue
  always @(negedge clock) begin
    for (int g = 0; g < 3; g++) begin
      if (ncr[g] === 1'b1) req_cnt[g]++;
      if (wr_en[g] === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write inst=%0d addr=%0d data=%0d", g, wr_addr[g], wr_data[g]);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_inst", 32'(g), 32'(e.inst));
          chk($sformatf("wr_addr_i%0d", g), 32'(wr_addr[g]), 32'(e.addr));
          chk($sformatf("wr_data_i%0d_a%0d", g, e.addr), 32'(wr_data[g]), 32'(e.data));
        end
      end
    end
  end

  task automatic push(input int g, input int addr, input int data);
    wr_t e;
    e.inst = g;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic check_reset(input int g, input string tag);
    chk({tag, "_req"},       32'(ncr[g]),        32'd0);
    chk({tag, "_wr_en"},     32'(wr_en[g]),      32'd0);
    chk({tag, "_busy"},      32'(busy[g]),       32'd0);
    chk({tag, "_done"},      32'(done[g]),       32'd0);
    chk({tag, "_wr_addr"},   32'(wr_addr[g]),    32'd0);
    chk({tag, "_wr_data"},   32'(wr_data[g]),    32'd0);
    chk({tag, "_bad_index"}, 32'(bad_index[g]),  32'd0);
    chk({tag, "_count"},     32'(char_count[g]), 32'd0);
    chk({tag, "_all_valid"}, 32'(all_valid[g]),  32'd1);
  endtask

  // Start a run; cyc is the cycle (1 = first after start-sampled edge) where done is seen
  task automatic run(input int g, input bit poke, input int budget, output int cyc);
    @(negedge clock);
    start[g] = 1'b1;
    @(negedge clock);
    start[g] = 1'b0;
    cyc = 1;
    while (done[g] !== 1'b1 && cyc < budget) begin
      @(negedge clock);
      cyc++;
      start[g] = poke && (cyc == 4);
    end
    start[g] = 1'b0;
  endtask

  initial begin
    int cyc;
    int r0;
    total    = 0;
    bad      = 0;
    reset    = 1'b1;
    start    = '0;
    override = 1'b0;
    repeat (3) @(negedge clock);
    check_reset(0, "reset");
    reset = 1'b0;

    // Alternating source, no stop; stray start mid-run must be ignored
    for (int i = 0; i < 4; i++) push(0, i, (i % 2 == 0) ? 97 + i / 2 : 95 + i / 2);
    r0 = req_cnt[0];
    run(0, 1'b1, 100, cyc);
    chk("A_done_cycle", 32'(cyc), 32'd13);
    chk("A_all_valid", 32'(all_valid[0]), 32'd0);
    chk("A_bad_index", 32'(bad_index[0]), 32'd1);
    chk("A_count", 32'(char_count[0]), 32'd4);
    @(negedge clock);
    chk("A_busy_after", 32'(busy[0]), 32'd0);
    chk("A_done_width", 32'(done[0]), 32'd0);
    chk("A_requests", 32'(req_cnt[0] - r0), 32'd4);
    chk("A_sb_empty", 32'(exp_q.size()), 32'd0);

    // Stop on first bad character
    pulse_reset();
    push(1, 0, 97);
    push(1, 1, 95);
    r0 = req_cnt[1];
    run(1, 1'b0, 100, cyc);
    chk("B_done_cycle", 32'(cyc), 32'd7);
    chk("B_count", 32'(char_count[1]), 32'd2);
    chk("B_bad_index", 32'(bad_index[1]), 32'd1);
    chk("B_all_valid", 32'(all_valid[1]), 32'd0);
    @(negedge clock);
    chk("B_busy_after", 32'(busy[1]), 32'd0);
    chk("B_requests", 32'(req_cnt[1] - r0), 32'd2);
    chk("B_sb_empty", 32'(exp_q.size()), 32'd0);

    // Full 32-character run: a..z then spaces, address reaches 31
    pulse_reset();
    for (int i = 0; i < 32; i++) push(2, i, (i < 26) ? 97 + i : 32);
    r0 = req_cnt[2];
    run(2, 1'b0, 300, cyc);
    chk("C_done_cycle", 32'(cyc), 32'd97);
    chk("C_all_valid", 32'(all_valid[2]), 32'd1);
    chk("C_count", 32'(char_count[2]), 32'd32);
    chk("C_bad_index", 32'(bad_index[2]), 32'd0);
    chk("C_requests", 32'(req_cnt[2] - r0), 32'd32);
    chk("C_sb_empty", 32'(exp_q.size()), 32'd0);

    // Upper bits set on an otherwise valid 'a'
    override = 1'b1;
    for (int i = 0; i < 4; i++) push(0, i, 8'h61);
    run(0, 1'b0, 100, cyc);
    override = 1'b0;
    chk("D_done_cycle", 32'(cyc), 32'd13);
    chk("D_all_valid", 32'(all_valid[0]), 32'd0);
    chk("D_bad_index", 32'(bad_index[0]), 32'd0);
    chk("D_count", 32'(char_count[0]), 32'd4);
    chk("D_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset during CAPTURE of char 2 (cycle 8), then restart
    pulse_reset();
    push(0, 0, 97);
    push(0, 1, 95);
    r0 = req_cnt[0];
    @(negedge clock);
    start[0] = 1'b1;
    @(negedge clock);
    start[0] = 1'b0;
    repeat (7) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_reset(0, "E_abort");
    reset = 1'b0;
    repeat (6) @(negedge clock);
    chk("E_busy_idle", 32'(busy[0]), 32'd0);
    chk("E_requests", 32'(req_cnt[0] - r0), 32'd3);
    chk("E_sb_empty", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 4; i++) push(0, i, (i % 2 == 0) ? 97 + i / 2 : 95 + i / 2);
    run(0, 1'b0, 100, cyc);
    chk("E_restart_done", 32'(cyc), 32'd13);
    chk("E_restart_count", 32'(char_count[0]), 32'd4);
    @(negedge clock);
    chk("E_restart_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
